// File: rtl/count_bus_reader.sv
// Reader/master for the loadable counter's tri-state count bus: presets the counter,
// periodically enables its driver, captures the bus and checks it against a shadow copy.
module count_bus_reader #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_GAP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] preset_val,
  input  logic [WIDTH-1:0] bus_in,
  output logic             cnt_load_en,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_oe,
  output logic             busy,
  output logic             sample_valid,
  output logic [WIDTH-1:0] sample_val,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic [2:0]       dbg_state_o
);

  localparam int GW = (SAMPLE_GAP < 2) ? 1 : $clog2(SAMPLE_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESET  = 3'd1,
    S_WAIT    = 3'd2,
    S_ENABLE  = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             valid_q;
  logic [WIDTH-1:0] sample_q;
  logic             mismatch_q;
  logic [7:0]       err_q;
  logic             capture_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      load_val_q <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      load_val_q <= load_val_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    load_val_d = load_val_q;
    capture_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PRESET;
          load_val_d = preset_val;
        end
      end
      S_PRESET: begin
        state_d = S_WAIT;
        gap_d   = GW'(SAMPLE_GAP);
      end
      S_WAIT: begin
        if (gap_q <= GW'(1)) state_d = S_ENABLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      S_ENABLE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        capture_go = 1'b1;
        if (auto_en) begin
          state_d = S_WAIT;
          gap_d   = GW'(SAMPLE_GAP);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including discarding an in-flight capture.
    if (abort) begin
      state_d    = S_IDLE;
      load_val_d = load_val_q;
      capture_go = 1'b0;
    end
  end

  // The counter loads during PRESET (load_en high) and counts on every other edge.
  always_comb begin
    shadow_d = shadow_q + WIDTH'(1);
    if (state_q == S_PRESET) shadow_d = load_val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      sample_q   <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      valid_q <= capture_go;
      if (capture_go) begin
        sample_q   <= bus_in;
        mismatch_q <= (bus_in != shadow_q);
        if ((bus_in != shadow_q) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
    end
  end

  assign cnt_load_en  = (state_q == S_PRESET);
  assign cnt_load_val = load_val_q;
  assign cnt_oe       = (state_q == S_ENABLE) || (state_q == S_CAPTURE);
  assign busy         = (state_q != S_IDLE);
  assign sample_valid = valid_q;
  assign sample_val   = sample_q;
  assign mismatch     = mismatch_q;
  assign err_count    = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_count_bus_reader.sv
// Bench for count_bus_reader: behavioural counter on the bus, scoreboard of expected captures.
module tb_count_bus_reader;

  localparam int W = 8;

  logic         clk, rst_n, start, abort, auto_en;
  logic [W-1:0] preset_val, bus_in;
  logic         cnt_load_en, cnt_oe, busy, sample_valid, mismatch;
  logic [W-1:0] cnt_load_val, sample_val;
  logic [7:0]   err_count;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  int seen  = 0;
  logic         force_bad;
  logic [W-1:0] cnt_model;
  logic [W:0]   exp_q[$];

  count_bus_reader #(.WIDTH(W), .SAMPLE_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .auto_en(auto_en),
    .preset_val(preset_val), .bus_in(bus_in),
    .cnt_load_en(cnt_load_en), .cnt_load_val(cnt_load_val), .cnt_oe(cnt_oe),
    .busy(busy), .sample_valid(sample_valid), .sample_val(sample_val),
    .mismatch(mismatch), .err_count(err_count), .dbg_state_o(dbg_state)
  );

  // Clock / reset-free clock generator
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter on the far side of the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_model <= '0;
    else if (cnt_load_en) cnt_model <= cnt_load_val;
    else                  cnt_model <= cnt_model + 8'd1;
  end

  always_comb begin
    bus_in = 8'h00;
    if (cnt_oe) bus_in = force_bad ? 8'hAA : cnt_model;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every sample_valid must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      logic [W:0] e;
      seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_sample_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sample_val", 32'(sample_val), 32'(e[W-1:0]));
        check("mismatch", 32'(mismatch), 32'(e[W]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] val, input logic auto);
    preset_val = val;
    auto_en    = auto;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_seen(input int target, input int budget, input string tag);
    int n = 0;
    while (seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, 32'(seen), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rnd;
    int base;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; auto_en = 1'b0;
    preset_val = '0; force_bad = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_load_en", 32'(cnt_load_en), 32'd0);
    check("rst_load_val", 32'(cnt_load_val), 32'd0);
    check("rst_oe", 32'(cnt_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_val", 32'(sample_val), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // 1. single read, preset 0x10, cycle-exact strobes
    exp_q.push_back({1'b0, 8'h15});
    pulse_start(8'h10, 1'b0);
    check("t1_preset_load_en", 32'(cnt_load_en), 32'd1);
    check("t1_preset_load_val", 32'(cnt_load_val), 32'h10);
    check("t1_preset_oe", 32'(cnt_oe), 32'd0);
    check("t1_preset_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_wait_load_en", 32'(cnt_load_en), 32'd0);
    check("t1_wait_oe", 32'(cnt_oe), 32'd0);
    tick(3);
    check("t1_wait_end_oe", 32'(cnt_oe), 32'd0);
    tick(1);
    check("t1_enable_oe", 32'(cnt_oe), 32'd1);
    tick(1);
    check("t1_capture_oe", 32'(cnt_oe), 32'd1);
    check("t1_capture_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_done_oe", 32'(cnt_oe), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_valid_pulse", 32'(sample_valid), 32'd1);
    wait_seen(1, 20, "t1_seen");
    tick(1);
    check("t1_valid_one_cycle", 32'(sample_valid), 32'd0);

    // 2. auto reads every 6 cycles; dropping auto_en ends after the next capture
    exp_q.push_back({1'b0, 8'h15});
    exp_q.push_back({1'b0, 8'h1B});
    exp_q.push_back({1'b0, 8'h21});
    exp_q.push_back({1'b0, 8'h27});
    pulse_start(8'h10, 1'b1);
    wait_seen(4, 60, "t2_seen3");
    auto_en = 1'b0;
    wait_seen(5, 20, "t2_seen4");
    wait_idle(20, "t2_idle");
    check("t2_err_count", 32'(err_count), 32'd0);

    // 3. wrap-around and a random preset
    exp_q.push_back({1'b0, 8'h01});
    tick(1);
    pulse_start(8'hFC, 1'b0);
    wait_seen(6, 20, "t3_seen_wrap");
    wait_idle(20, "t3_idle");
    rnd = 8'($urandom_range(0, 255));
    exp_q.push_back({1'b0, 8'(rnd + 8'd5)});
    tick(1);
    pulse_start(rnd, 1'b0);
    wait_seen(7, 20, "t3_seen_rand");
    wait_idle(20, "t3_idle_rand");

    // 4. forced bad bus value, then saturation of err_count
    force_bad = 1'b1;
    exp_q.push_back({1'b1, 8'hAA});
    tick(1);
    pulse_start(8'h10, 1'b0);
    wait_seen(8, 20, "t4_seen");
    check("t4_err_one", 32'(err_count), 32'd1);
    wait_idle(20, "t4_idle");
    for (int i = 0; i < 300; i++) exp_q.push_back({1'b1, 8'hAA});
    base = seen;
    tick(1);
    pulse_start(8'h00, 1'b1);
    wait_seen(base + 299, 2000, "t4_seen_many");
    auto_en = 1'b0;
    wait_seen(base + 300, 20, "t4_seen_last");
    wait_idle(20, "t4_idle_sat");
    check("t4_err_saturated", 32'(err_count), 32'hFF);
    force_bad = 1'b0;

    // 5. start during busy ignored; abort in ENABLE
    exp_q.push_back({1'b0, 8'h45});
    base = seen;
    tick(1);
    pulse_start(8'h40, 1'b0);
    tick(1);
    pulse_start(8'h99, 1'b0);
    check("t5_ignored_start_load_en", 32'(cnt_load_en), 32'd0);
    wait_seen(base + 1, 20, "t5_seen");
    check("t5_mismatch_cleared", 32'(mismatch), 32'd0);
    check("t5_err_retained", 32'(err_count), 32'hFF);
    wait_idle(20, "t5_idle");
    base = seen;
    tick(1);
    pulse_start(8'h30, 1'b0);
    tick(5);
    check("t5_in_enable_oe", 32'(cnt_oe), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_oe", 32'(cnt_oe), 32'd0);
    tick(10);
    check("t5_abort_no_sample", 32'(seen), 32'(base));

    // 6. reset during CAPTURE with auto_en=1
    pulse_start(8'h50, 1'b1);
    tick(6);
    check("t6_in_capture_oe", 32'(cnt_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", 32'(cnt_oe), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_load_val", 32'(cnt_load_val), 32'd0);
    check("t6_rst_sample_val", 32'(sample_val), 32'd0);
    check("t6_rst_err_count", 32'(err_count), 32'd0);
    check("t6_rst_valid", 32'(sample_valid), 32'd0);
    auto_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    base = seen;
    exp_q.push_back({1'b0, 8'h05});
    pulse_start(8'h00, 1'b0);
    wait_seen(base + 1, 20, "t6_seen");
    wait_idle(20, "t6_idle");

    // abort in CAPTURE discards a capture that would have mismatched
    force_bad = 1'b1;
    base = seen;
    tick(1);
    pulse_start(8'h20, 1'b0);
    tick(6);
    check("t7_in_capture_oe", 32'(cnt_oe), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t7_abort_oe", 32'(cnt_oe), 32'd0);
    tick(4);
    check("t7_no_sample", 32'(seen), 32'(base));
    check("t7_err_unchanged", 32'(err_count), 32'd0);
    force_bad = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
